rt_mu_sequencer: RTL and testbench

//  Transaction sequencer for one racetrack memory unit (Nr lines x Nb bits, Np ports).

---
 rtl/rt_ctrl_pkg.sv | 9 +
 rtl/rt_phase_timer.sv | 17 +
 rtl/rt_mu_sequencer.sv | 122 ++++++++++++
 tb/tb_rt_mu_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_ctrl_pkg.sv
// rt_ctrl_pkg: shared states, request targets and control-vector bit indices for the MU sequencer
package rt_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, WR, SS, SM, LS, LM, RD, RESP} state_e;
    typedef enum logic [1:0] {TGT_DATA, TGT_MASK, TGT_PROG, TGT_RSVD} tgt_e;
    localparam int IDX_DATA = 0;
    localparam int IDX_MASK = 1;
    localparam int IDX_PROG = 2;
    localparam int IDX_LIM  = 3;
endpackage

// File: rtl/rt_phase_timer.sv
// rt_phase_timer: loadable down-counter; done marks the last cycle of a phase
module rt_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= load ? len : (cnt != '0 ? cnt - W'(1) : cnt);
    end
    assign done = cnt == W'(1);
endmodule

// File: rtl/rt_mu_sequencer.sv
// rt_mu_sequencer: req/gnt/rvalid front end sequencing write, shift and read phases of one racetrack MU
module rt_mu_sequencer
    import rt_ctrl_pkg::*;
#(
    parameter int NR   = 4,
    parameter int NB   = 32,
    parameter int T_PH = 2,
    parameter int T_RD = 2,
    localparam int AW  = $clog2(NB)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          req_i,
    output logic          gnt_o,
    input  logic          we_i,
    input  logic          lim_i,
    input  logic [1:0]    tgt_i,
    input  logic [AW-1:0] addr_i,
    input  logic [NR-1:0] wdata_i,
    output logic          rvalid_o,
    output logic [NR-1:0] rdata_o,
    output logic          err_o,
    output logic [NB-1:0] word_lines_o,
    output logic [NR-1:0] write_i_o,
    output logic [2:0]    write_en_o,
    output logic [3:0]    cur_s_o,
    output logic [3:0]    cur_m_o,
    output logic [2:0]    rd_cur_o,
    output logic          bz_s_o,
    output logic          bz_m_o,
    output logic          out_select_o,
    input  logic [NR-1:0] r_data_i,
    input  logic [NR-1:0] r_data_m_i,
    input  logic [NR-1:0] r_data_p_i
);
    localparam int TMAX = T_PH > T_RD ? T_PH : T_RD;
    localparam int CW   = $clog2(TMAX + 1);

    state_e        state, nxt;
    tgt_e          r_tgt, f_tgt;
    logic          r_lim, f_lim, illegal, done, act;
    logic [AW-1:0] r_addr, f_addr;
    logic [NR-1:0] r_wdata, f_wdata, bus;
    logic [CW-1:0] len;

    assign gnt_o   = req_i && state == IDLE;
    assign illegal = tgt_e'(tgt_i) == TGT_RSVD || (lim_i && we_i) || int'(addr_i) >= NB;
    // On the grant edge the outputs must already reflect the new request, not the stale registers
    assign f_tgt   = gnt_o ? tgt_e'(tgt_i) : r_tgt;
    assign f_lim   = gnt_o ? lim_i : r_lim;
    assign f_addr  = gnt_o ? addr_i : r_addr;
    assign f_wdata = gnt_o ? wdata_i : r_wdata;
    assign act     = nxt inside {WR, SS, SM, LS, LM, RD};
    assign len     = nxt inside {SS, SM, LS, LM} ? CW'(T_PH) : nxt == RD ? CW'(T_RD) : CW'(1);
    assign bus     = r_lim || r_tgt == TGT_DATA ? r_data_i : r_tgt == TGT_MASK ? r_data_m_i : r_data_p_i;

    rt_phase_timer #(.W(CW)) u_timer (
        .clk  (clk_i),
        .rst_n(rstn_i),
        .load (nxt != state),
        .len  (len),
        .done (done)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !gnt_o ? IDLE : illegal ? RESP : we_i ? WR : lim_i ? LS : RD;
            WR:      nxt = done ? SS : WR;
            SS:      nxt = done ? SM : SS;
            SM:      nxt = done ? RESP : SM;
            LS:      nxt = done ? LM : LS;
            LM:      nxt = done ? RD : LM;
            RD:      nxt = done ? RESP : RD;
            RESP:    nxt = done ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    // Outputs decode the next state so every MU drive line comes straight from a flop
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            r_tgt        <= TGT_DATA;
            r_lim        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            rvalid_o     <= 1'b0;
            err_o        <= 1'b0;
            rdata_o      <= '0;
            word_lines_o <= '0;
            write_i_o    <= '0;
            write_en_o   <= '0;
            cur_s_o      <= '0;
            cur_m_o      <= '0;
            rd_cur_o     <= '0;
            bz_s_o       <= 1'b0;
            bz_m_o       <= 1'b0;
            out_select_o <= 1'b0;
        end else begin
            state <= nxt;
            if (gnt_o) begin
                r_tgt   <= tgt_e'(tgt_i);
                r_lim   <= lim_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            rvalid_o     <= nxt == RESP;
            err_o        <= nxt == RESP && state == IDLE;
            rdata_o      <= nxt == RESP && state == RD ? bus : '0;
            word_lines_o <= act ? NB'(1) << f_addr : '0;
            write_i_o    <= nxt == WR ? f_wdata : '0;
            write_en_o   <= nxt == WR ? 3'(1) << f_tgt : '0;
            cur_s_o      <= nxt == SS ? 4'(1) << f_tgt : nxt == LS ? 4'(1) << IDX_LIM : '0;
            cur_m_o      <= nxt == SM ? 4'(1) << f_tgt : nxt == LM ? 4'(1) << IDX_LIM : '0;
            rd_cur_o     <= nxt != RD ? '0 : f_lim ? 3'(1) << IDX_DATA : 3'(1) << f_tgt;
            bz_s_o       <= nxt == LS;
            bz_m_o       <= nxt == LM;
            out_select_o <= nxt == RD && f_lim;
        end
    end
endmodule

// File: tb/tb_rt_mu_sequencer.sv
// tb_rt_mu_sequencer: sequencer plus a behavioural MU, checked every cycle against a transaction-level model
module tb_rt_mu_sequencer;
    localparam int NR = 4, NB = 32, T_PH = 2, T_RD = 2, AW = 5;

    logic          clk = 1'b0, rstn = 1'b0, req = 1'b0, we = 1'b0, lim = 1'b0;
    logic [1:0]    tgt = '0;
    logic [AW-1:0] addr = '0;
    logic [NR-1:0] wdata = '0;
    logic          gnt_o, rvalid_o, err_o, bz_s_o, bz_m_o, out_select_o;
    logic [NR-1:0] rdata_o, write_i_o, r_data, r_data_m, r_data_p;
    logic [NB-1:0] word_lines_o;
    logic [2:0]    write_en_o, rd_cur_o;
    logic [3:0]    cur_s_o, cur_m_o;
    int            checks = 0, fails = 0;

    always #5 clk = ~clk;

    rt_mu_sequencer #(.NR(NR), .NB(NB), .T_PH(T_PH), .T_RD(T_RD)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .gnt_o(gnt_o), .we_i(we), .lim_i(lim),
        .tgt_i(tgt), .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .word_lines_o(word_lines_o), .write_i_o(write_i_o), .write_en_o(write_en_o),
        .cur_s_o(cur_s_o), .cur_m_o(cur_m_o), .rd_cur_o(rd_cur_o), .bz_s_o(bz_s_o), .bz_m_o(bz_m_o),
        .out_select_o(out_select_o), .r_data_i(r_data), .r_data_m_i(r_data_m), .r_data_p_i(r_data_p)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] limf(input logic [NR-1:0] d, m, p);
        return (d & m) ^ p;
    endfunction

    // Behavioural MU: stores on write enable, drives its buses only while the matching read current flows
    logic [NR-1:0] mu_d[NB], mu_m[NB], mu_p[NB], rf_d[NB], rf_m[NB], rf_p[NB];
    logic          mu_init = 1'b0, rf_init = 1'b0;
    int            wl_idx;
    always_comb begin
        wl_idx = 0;
        for (int i = 0; i < NB; i++) if (word_lines_o[i]) wl_idx = i;
    end
    always_comb begin
        r_data   = rd_cur_o[0] ? (out_select_o ? limf(mu_d[wl_idx], mu_m[wl_idx], mu_p[wl_idx]) : mu_d[wl_idx]) : '0;
        r_data_m = rd_cur_o[1] ? mu_m[wl_idx] : '0;
        r_data_p = rd_cur_o[2] ? mu_p[wl_idx] : '0;
    end
    always @(posedge clk) begin
        if (!mu_init && rf_init) begin
            for (int i = 0; i < NB; i++) begin
                mu_d[i] <= rf_d[i];
                mu_m[i] <= rf_m[i];
                mu_p[i] <= rf_p[i];
            end
            mu_init <= 1'b1;
        end else begin
            if (write_en_o[0]) mu_d[wl_idx] <= write_i_o;
            if (write_en_o[1]) mu_m[wl_idx] <= write_i_o;
            if (write_en_o[2]) mu_p[wl_idx] <= write_i_o;
        end
    end

    typedef struct packed {
        logic [NB-1:0] wl;
        logic [NR-1:0] wi;
        logic [2:0]    wen;
        logic [3:0]    cs, cm;
        logic [2:0]    rc;
        logic          bzs, bzm, osel, rv;
        logic [NR-1:0] rd;
        logic          er;
    } exp_t;
    exp_t q[$];
    int   bzs_n = 0, bzm_n = 0, osel_n = 0, gnt_n = 0;

    // Expand an accepted request into the output vector expected on each following cycle
    task automatic expand();
        exp_t b, x;
        b = '0;
        if (tgt == 2'd3 || (lim && we) || int'(addr) >= NB) begin
            b.rv = 1'b1;
            b.er = 1'b1;
            q.push_back(b);
            return;
        end
        b.wl = NB'(1) << addr;
        if (we) begin
            x = b; x.wi = wdata; x.wen[tgt] = 1'b1; q.push_back(x);
            x = b; x.cs[tgt] = 1'b1; repeat (T_PH) q.push_back(x);
            x = b; x.cm[tgt] = 1'b1; repeat (T_PH) q.push_back(x);
            if (tgt == 2'd0) rf_d[addr] = wdata;
            else if (tgt == 2'd1) rf_m[addr] = wdata;
            else rf_p[addr] = wdata;
            x = '0; x.rv = 1'b1; q.push_back(x);
        end else begin
            if (lim) begin
                x = b; x.cs[3] = 1'b1; x.bzs = 1'b1; repeat (T_PH) q.push_back(x);
                x = b; x.cm[3] = 1'b1; x.bzm = 1'b1; repeat (T_PH) q.push_back(x);
            end
            x = b; x.rc[lim ? 0 : int'(tgt)] = 1'b1; x.osel = lim; repeat (T_RD) q.push_back(x);
            x = '0; x.rv = 1'b1;
            x.rd = lim ? limf(rf_d[addr], rf_m[addr], rf_p[addr]) :
                   tgt == 2'd0 ? rf_d[addr] : tgt == 2'd1 ? rf_m[addr] : rf_p[addr];
            q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic eg;
        if (!rf_init) begin
            for (int i = 0; i < NB; i++) begin
                rf_d[i] = NR'($urandom);
                rf_m[i] = NR'($urandom);
                rf_p[i] = NR'($urandom);
            end
            rf_init = 1'b1;
        end
        if (!rstn) q.delete();
        e  = q.size() != 0 ? q[0] : '0;
        eg = req && q.size() == 0;
        chk("gnt", gnt_o, eg);
        chk("word_lines", word_lines_o, e.wl);
        chk("write_i", write_i_o, e.wi);
        chk("write_en", write_en_o, e.wen);
        chk("cur_s", cur_s_o, e.cs);
        chk("cur_m", cur_m_o, e.cm);
        chk("rd_cur", rd_cur_o, e.rc);
        chk("bz_s", bz_s_o, e.bzs);
        chk("bz_m", bz_m_o, e.bzm);
        chk("out_select", out_select_o, e.osel);
        chk("rvalid", rvalid_o, e.rv);
        chk("rdata", rdata_o, e.rd);
        chk("err", err_o, e.er);
        bzs_n  += int'(bz_s_o);
        bzm_n  += int'(bz_m_o);
        osel_n += int'(out_select_o);
        gnt_n  += int'(gnt_o);
        if (q.size() != 0) void'(q.pop_front());
        if (rstn && eg) expand();
    end

    task automatic scramble();
        we    = 1'($urandom);
        lim   = 1'($urandom);
        tgt   = 2'($urandom);
        addr  = AW'($urandom);
        wdata = NR'($urandom);
    endtask

    task automatic issue(input logic w, l, input logic [1:0] t, input logic [AW-1:0] a,
                         input logic [NR-1:0] d, output int gw);
        req = 1'b1; we = w; lim = l; tgt = t; addr = a; wdata = d;
        gw = 0;
        do begin @(negedge clk); gw++; end while (!gnt_o && gw < 100);
        chk("gnt_timeout", gnt_o, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic txn(input logic w, l, input logic [1:0] t, input logic [AW-1:0] a,
                       input logic [NR-1:0] d, output int lat, output logic [NR-1:0] rd,
                       output logic er, output int gw);
        issue(w, l, t, a, d, gw);
        req = 1'b0;
        scramble();
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rvalid_o && lat < 100);
        chk("rvalid_timeout", rvalid_o, 1'b1);
        rd = rdata_o;
        er = err_o;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, gw, g0, b0, m0, o0;
        logic [NR-1:0] rd;
        logic er;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("reset_rvalid", rvalid_o, 1'b0);
        chk("reset_word_lines", word_lines_o, '0);
        @(posedge clk); #1;

        txn(1, 0, 0, 5, 4'hA, lat, rd, er, gw);
        chk("wr_latency", lat, 6);
        chk("wr_err", er, 1'b0);
        txn(0, 0, 0, 5, 0, lat, rd, er, gw);
        chk("rd_latency", lat, 3);
        chk("rd_data", rd, 4'hA);

        txn(1, 0, 0, 31, 4'h5, lat, rd, er, gw);
        txn(1, 0, 1, 31, 4'h3, lat, rd, er, gw);
        txn(1, 0, 2, 31, 4'hC, lat, rd, er, gw);
        txn(0, 0, 1, 31, 0, lat, rd, er, gw);
        chk("rd_mask31", rd, 4'h3);
        txn(0, 0, 2, 31, 0, lat, rd, er, gw);
        chk("rd_prog31", rd, 4'hC);
        txn(0, 0, 0, 31, 0, lat, rd, er, gw);
        chk("rd_data31", rd, 4'h5);

        txn(1, 0, 0, 9, 4'hC, lat, rd, er, gw);
        txn(1, 0, 1, 9, 4'hA, lat, rd, er, gw);
        txn(1, 0, 2, 9, 4'h6, lat, rd, er, gw);
        b0 = bzs_n; m0 = bzm_n; o0 = osel_n;
        txn(0, 1, 0, 9, 0, lat, rd, er, gw);
        chk("lim_latency", lat, 7);
        chk("lim_data", rd, 4'hE);
        chk("lim_bz_s_cycles", bzs_n - b0, 2);
        chk("lim_bz_m_cycles", bzm_n - m0, 2);
        chk("lim_osel_cycles", osel_n - o0, 2);

        txn(0, 0, 3, 4, 0, lat, rd, er, gw);
        chk("err_tgt_latency", lat, 1);
        chk("err_tgt_flag", er, 1'b1);
        chk("err_tgt_rdata", rd, 4'h0);
        txn(1, 1, 0, 4, 4'hF, lat, rd, er, gw);
        chk("err_limwe_latency", lat, 1);
        chk("err_limwe_flag", er, 1'b1);

        g0 = gnt_n;
        issue(0, 0, 0, 5, 0, gw);
        chk("b2b_first_gnt", gw, 1);
        issue(0, 0, 1, 31, 0, gw);
        chk("b2b_second_gnt", gw, 4);
        issue(0, 0, 2, 31, 0, gw);
        chk("b2b_third_gnt", gw, 4);
        req = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("b2b_gnt_count", gnt_n - g0, 3);

        issue(1, 0, 0, 7, 4'h9, gw);
        req = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("rst_async_cur_s", cur_s_o, '0);
        chk("rst_async_word_lines", word_lines_o, '0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        txn(0, 0, 0, 7, 0, lat, rd, er, gw);
        chk("post_reset_gnt", gw, 1);

        repeat (150) begin
            scramble();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            txn(1'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), AW'($urandom), NR'($urandom),
                lat, rd, er, gw);
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
